mem_stage_ctrl: RTL and testbench

//  Memory-stage reader of the 76-bit EX/MEM buffer. Decodes each buffered instruction and runs a

---
 rtl/mem_stage_pkg.sv | 67 ++++++
 rtl/mem_stage_ctrl_watchdog.sv | 39 +++
 rtl/mem_stage_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - EX/MEM field layout, FSM encoding and op decode for the memory stage
package mem_stage_pkg;

    localparam int EXM_W      = 76;
    localparam int DATA_LSB   = 0;
    localparam int DATA_MSB   = 31;
    localparam int WBA_LSB    = 32;
    localparam int WBA_MSB    = 34;
    localparam int MR_BIT     = 35;
    localparam int MW_BIT     = 36;
    localparam int WB_BIT     = 37;
    localparam int ADDR_LSB   = 38;
    localparam int ADDR_MSB   = 69;
    localparam int JWSP_BIT   = 70;
    localparam int SPC_BIT    = 71;
    localparam int SFL_BIT    = 72;
    localparam int FL_LSB     = 73;
    localparam int FL_MSB     = 75;

    localparam int MEM_WORD_W = 16;
    localparam int MEM_ADDR_W = 32;
    localparam int WB_ADDR_W  = 3;
    localparam int FLAGS_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_PUSH_PC = 3'd1,
        OP_POP_PC  = 3'd2,
        OP_PUSH_FL = 3'd3,
        OP_POP_FL  = 3'd4,
        OP_STORE   = 3'd5,
        OP_LOAD    = 3'd6
    } op_e;

    // Fields of the buffered instruction still needed after the op has been decoded
    typedef struct packed {
        logic [31:0]           data;
        logic [WB_ADDR_W-1:0]  wb_addr;
        logic                  wb;
        logic [MEM_ADDR_W-1:0] addr;
        logic [FLAGS_W-1:0]    flags;
    } exm_fields_t;

    // Highest-priority memory operation encoded in an EX/MEM word
    function automatic op_e decode_op(input logic [EXM_W-1:0] x);
        logic pc_push;
        logic call_push;
        // a call push (JWSP set) takes exactly the same path as a plain PC push
        pc_push   = x[SPC_BIT] & x[MW_BIT];
        call_push = x[JWSP_BIT] & pc_push;
        if (pc_push || call_push)             return OP_PUSH_PC;
        else if (x[SPC_BIT] && x[MR_BIT])     return OP_POP_PC;
        else if (x[SFL_BIT] && x[MW_BIT])     return OP_PUSH_FL;
        else if (x[SFL_BIT] && x[MR_BIT])     return OP_POP_FL;
        else if (x[MW_BIT])                   return OP_STORE;
        else if (x[MR_BIT])                   return OP_LOAD;
        else                                  return OP_NONE;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_watchdog.sv
// rtl/mem_stage_ctrl_watchdog.sv - counts unacknowledged request cycles and flags an abort
module mem_ack_watchdog #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The count restarts on every ack and whenever no request is outstanding; the
    // MAX_WAIT-th unacked cycle expires, but an ack in that same cycle takes precedence.
    always_comb begin
        cnt_d    = '0;
        expire_o = 1'b0;
        if (active_i && !ack_i) begin
            if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                expire_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory stage: EX/MEM decode, data-memory handshake, MEM/WB outputs
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WORD_W   = 16,
    parameter int ADDR_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXM_W-1:0]     ex_mem_in,
    input  logic                 in_valid,
    output logic                 stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_W-1:0]    mem_wdata,
    input  logic [WORD_W-1:0]    mem_rdata,
    input  logic                 mem_ack,
    output logic                 wb_valid,
    output logic                 wb_en,
    output logic [WB_ADDR_W-1:0] wb_addr,
    output logic [WORD_W-1:0]    wb_data,
    output logic [ADDR_W-1:0]    pc_restore,
    output logic                 pc_restore_valid,
    output logic [FLAGS_W-1:0]   flags_restore,
    output logic                 flags_restore_valid,
    output logic                 mem_err
);

    state_e      state_q, state_d;
    op_e         op_q, in_op;
    exm_fields_t cap_q;
    logic        conflict_q;
    logic [WORD_W-1:0] rd0_q, rd1_q;
    logic        in_acc, ack_ok, expire, two_word;

    assign in_op    = decode_op(ex_mem_in);
    assign in_acc   = (state_q == ST_ACC0) || (state_q == ST_ACC1);
    // an ack with no request outstanding (e.g. one left over from before a reset) is ignored
    assign ack_ok   = mem_ack && mem_req;
    assign two_word = (op_q == OP_PUSH_PC) || (op_q == OP_POP_PC);

    mem_ack_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .active_i (in_acc),
        .ack_i    (ack_ok),
        .expire_o (expire)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: pass-through instructions skip straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = (in_op == OP_NONE) ? ST_DONE : ST_ACC0;
            ST_ACC0: begin
                if (ack_ok)      state_d = two_word ? ST_ACC1 : ST_DONE;
                else if (expire) state_d = ST_IDLE;
            end
            ST_ACC1: begin
                if (ack_ok)      state_d = ST_DONE;
                else if (expire) state_d = ST_IDLE;
            end
            default:             state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: request fields derive only from state and captured data, so they hold while mem_req=1.
    // The DONE cycle of a pass-through instruction is not stalled so ALU traffic flows without bubbles.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall     = 1'b0;
        case (state_q)
            ST_ACC0: begin
                mem_req  = 1'b1;
                stall    = 1'b1;
                mem_addr = cap_q.addr;
                case (op_q)
                    OP_PUSH_PC: begin mem_we = 1'b1; mem_wdata = cap_q.data[31:16]; end
                    OP_PUSH_FL: begin mem_we = 1'b1; mem_wdata = {{(WORD_W-FLAGS_W){1'b0}}, cap_q.flags}; end
                    OP_STORE:   begin mem_we = 1'b1; mem_wdata = cap_q.data[15:0]; end
                    default:    ;
                endcase
            end
            ST_ACC1: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (op_q == OP_PUSH_PC) begin
                    mem_we    = 1'b1;
                    mem_wdata = cap_q.data[15:0];
                    mem_addr  = cap_q.addr - 32'd1;
                end else begin
                    mem_addr  = cap_q.addr + 32'd1;
                end
            end
            ST_DONE: stall = (op_q != OP_NONE);
            default: ;
        endcase
    end

    // Capture register and read-data holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q      <= '0;
            op_q       <= OP_NONE;
            conflict_q <= 1'b0;
            rd0_q      <= '0;
            rd1_q      <= '0;
        end else begin
            if (state_q == ST_IDLE && in_valid) begin
                cap_q.data    <= ex_mem_in[DATA_MSB:DATA_LSB];
                cap_q.wb_addr <= ex_mem_in[WBA_MSB:WBA_LSB];
                cap_q.wb      <= ex_mem_in[WB_BIT];
                cap_q.addr    <= ex_mem_in[ADDR_MSB:ADDR_LSB];
                cap_q.flags   <= ex_mem_in[FL_MSB:FL_LSB];
                op_q          <= in_op;
                conflict_q    <= ex_mem_in[MR_BIT] & ex_mem_in[MW_BIT];
            end
            if (state_q == ST_ACC0 && ack_ok) rd0_q <= mem_rdata;
            if (state_q == ST_ACC1 && ack_ok) rd1_q <= mem_rdata;
        end
    end

    // MEM/WB and restore outputs: one-cycle valid pulses on leaving DONE or on a watchdog abort
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid            <= 1'b0;
            wb_en               <= 1'b0;
            wb_addr             <= '0;
            wb_data             <= '0;
            pc_restore          <= '0;
            pc_restore_valid    <= 1'b0;
            flags_restore       <= '0;
            flags_restore_valid <= 1'b0;
            mem_err             <= 1'b0;
        end else begin
            wb_valid            <= 1'b0;
            wb_en               <= 1'b0;
            pc_restore_valid    <= 1'b0;
            flags_restore_valid <= 1'b0;
            mem_err             <= 1'b0;
            if (state_q == ST_DONE) begin
                wb_valid <= 1'b1;
                wb_en    <= cap_q.wb;
                wb_addr  <= cap_q.wb_addr;
                wb_data  <= (op_q == OP_LOAD) ? rd0_q : cap_q.data[15:0];
                mem_err  <= conflict_q;
                if (op_q == OP_POP_PC) begin
                    pc_restore       <= {rd1_q, rd0_q};
                    pc_restore_valid <= 1'b1;
                end
                if (op_q == OP_POP_FL) begin
                    flags_restore       <= rd0_q[FLAGS_W-1:0];
                    flags_restore_valid <= 1'b1;
                end
            end else if (expire) begin
                wb_valid <= 1'b1;
                mem_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [75:0] ex_mem_in;
    logic        in_valid;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [31:0] pc_restore;
    logic        pc_restore_valid;
    logic [2:0]  flags_restore;
    logic        flags_restore_valid;
    logic        mem_err;

    int tests = 0;
    int fails = 0;

    mem_stage_ctrl #(.MAX_WAIT(15), .WORD_W(16), .ADDR_W(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ex_mem_in           (ex_mem_in),
        .in_valid            (in_valid),
        .stall               (stall),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_rdata           (mem_rdata),
        .mem_ack             (mem_ack),
        .wb_valid            (wb_valid),
        .wb_en               (wb_en),
        .wb_addr             (wb_addr),
        .wb_data             (wb_data),
        .pc_restore          (pc_restore),
        .pc_restore_valid    (pc_restore_valid),
        .flags_restore       (flags_restore),
        .flags_restore_valid (flags_restore_valid),
        .mem_err             (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [75:0] mk(input logic [31:0] data, input logic [2:0] wba,
                                       input logic mr, input logic mw, input logic wb,
                                       input logic [31:0] addr, input logic jwsp,
                                       input logic spc, input logic sfl, input logic [2:0] fl);
        return {fl, sfl, spc, jwsp, addr, wb, mw, mr, wba, data};
    endfunction

    task automatic issue(input logic [75:0] v);
        ex_mem_in = v;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        ex_mem_in = '0;
    endtask

    // Expect a request now, keep it waiting for 'delay' cycles, then acknowledge it once
    task automatic serve(input string tag, input logic [31:0] a, input logic we,
                         input logic [15:0] wd, input int delay, input logic [15:0] rd);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, we});
        if (we) chk({tag, "_wdata"}, {16'd0, mem_wdata}, {16'd0, wd});
        for (int i = 0; i < delay; i++) begin
            step();
            chk({tag, "_hold_req"}, {31'd0, mem_req}, 32'd1);
            chk({tag, "_hold_addr"}, mem_addr, a);
            chk({tag, "_hold_stall"}, {31'd0, stall}, 32'd1);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        ex_mem_in = '0;
        in_valid  = 1'b0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst_pc_restore", pc_restore, 32'd0);

        // 1: ALU pass-through
        issue(mk(32'h0000_00AB, 3'd5, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0));
        chk("alu_stall0", {31'd0, stall}, 32'd0);
        chk("alu_early_valid", {31'd0, wb_valid}, 32'd0);
        step();
        chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("alu_wb_data", {16'd0, wb_data}, 32'h00AB);
        chk("alu_wb_addr", {29'd0, wb_addr}, 32'd5);
        chk("alu_wb_en", {31'd0, wb_en}, 32'd1);
        chk("alu_stall1", {31'd0, stall}, 32'd0);
        step();
        chk("alu_pulse_end", {31'd0, wb_valid}, 32'd0);

        // 2: load with a 5-cycle ack delay
        issue(mk(32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 3'd0));
        chk("ld_stall", {31'd0, stall}, 32'd1);
        serve("ld", 32'h20, 1'b0, 16'h0, 5, 16'h1234);
        chk("ld_done_stall", {31'd0, stall}, 32'd1);
        chk("ld_done_req", {31'd0, mem_req}, 32'd0);
        step();
        chk("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("ld_wb_data", {16'd0, wb_data}, 32'h1234);
        chk("ld_wb_en", {31'd0, wb_en}, 32'd1);
        chk("ld_wb_addr", {29'd0, wb_addr}, 32'd2);

        // 3: PC push, high word first, then low word one address down
        issue(mk(32'hDEAD_BEEF, 3'd0, 1'b0, 1'b1, 1'b0, 32'h3FF, 1'b0, 1'b1, 1'b0, 3'd0));
        serve("push0", 32'h3FF, 1'b1, 16'hDEAD, 0, 16'h0);
        serve("push1", 32'h3FE, 1'b1, 16'hBEEF, 1, 16'h0);
        step();
        chk("push_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("push_wb_en", {31'd0, wb_en}, 32'd0);
        chk("push_pcv", {31'd0, pc_restore_valid}, 32'd0);

        // 4: PC pop with address wrap
        issue(mk(32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 3'd0));
        serve("pop0", 32'hFFFF_FFFF, 1'b0, 16'h0, 0, 16'hBEEF);
        serve("pop1", 32'h0000_0000, 1'b0, 16'h0, 0, 16'hDEAD);
        step();
        chk("pop_pc", pc_restore, 32'hDEAD_BEEF);
        chk("pop_pcv", {31'd0, pc_restore_valid}, 32'd1);
        step();
        chk("pop_pcv_end", {31'd0, pc_restore_valid}, 32'd0);

        // 5: flags pop, flags push, MR&MW conflict
        issue(mk(32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 1'b1, 3'd0));
        serve("flpop", 32'h40, 1'b0, 16'h0, 2, 16'h0005);
        step();
        chk("flpop_flags", {29'd0, flags_restore}, 32'd5);
        chk("flpop_valid", {31'd0, flags_restore_valid}, 32'd1);
        chk("flpop_pcv", {31'd0, pc_restore_valid}, 32'd0);
        issue(mk(32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h41, 1'b0, 1'b0, 1'b1, 3'b110));
        serve("flpush", 32'h41, 1'b1, 16'h0006, 0, 16'h0);
        step();
        chk("flpush_valid", {31'd0, flags_restore_valid}, 32'd0);
        chk("flpush_err", {31'd0, mem_err}, 32'd0);
        issue(mk(32'h0000_5A5A, 3'd1, 1'b1, 1'b1, 1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 3'd0));
        serve("conf", 32'h50, 1'b1, 16'h5A5A, 0, 16'h7777);
        step();
        chk("conf_err", {31'd0, mem_err}, 32'd1);
        chk("conf_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("conf_wb_data", {16'd0, wb_data}, 32'h5A5A);
        step();
        chk("conf_err_end", {31'd0, mem_err}, 32'd0);

        // 6: watchdog abort after 15 unacked cycles
        issue(mk(32'h0, 3'd3, 1'b1, 1'b0, 1'b1, 32'h60, 1'b0, 1'b0, 1'b0, 3'd0));
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("wd_req_cycles", n, 32'd15);
        chk("wd_err", {31'd0, mem_err}, 32'd1);
        chk("wd_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("wd_wb_en", {31'd0, wb_en}, 32'd0);
        chk("wd_stall", {31'd0, stall}, 32'd0);
        step();
        chk("wd_err_end", {31'd0, mem_err}, 32'd0);

        // ack in the cycle the count would expire wins
        issue(mk(32'h0, 3'd4, 1'b1, 1'b0, 1'b1, 32'h70, 1'b0, 1'b0, 1'b0, 3'd0));
        serve("late", 32'h70, 1'b0, 16'h0, 14, 16'hCAFE);
        chk("late_err_done", {31'd0, mem_err}, 32'd0);
        chk("late_stall", {31'd0, stall}, 32'd1);
        step();
        chk("late_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("late_wb_data", {16'd0, wb_data}, 32'hCAFE);
        chk("late_err", {31'd0, mem_err}, 32'd0);

        // each ack restarts the count: two 10-cycle waits in one call push, downward wrap
        issue(mk(32'h1357_2468, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0));
        serve("call0", 32'h0, 1'b1, 16'h1357, 10, 16'h0);
        serve("call1", 32'hFFFF_FFFF, 1'b1, 16'h2468, 10, 16'h0);
        step();
        chk("call_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("call_err", {31'd0, mem_err}, 32'd0);

        // reset during ACC1, then a stale ack
        issue(mk(32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 3'd0));
        serve("rpop0", 32'h100, 1'b0, 16'h0, 0, 16'h1111);
        chk("racc1_req", {31'd0, mem_req}, 32'd1);
        chk("racc1_addr", mem_addr, 32'h101);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmid_req", {31'd0, mem_req}, 32'd0);
        chk("rmid_stall", {31'd0, stall}, 32'd0);
        chk("rmid_addr", mem_addr, 32'd0);
        chk("rmid_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rmid_wb_data", {16'd0, wb_data}, 32'd0);
        chk("rmid_pc", pc_restore, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 16'h2222;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        chk("stale_req", {31'd0, mem_req}, 32'd0);
        chk("stale_stall", {31'd0, stall}, 32'd0);
        step();
        chk("stale_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("stale_pcv", {31'd0, pc_restore_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
